// File: rtl/load_store_unit.sv
// RV32I load/store stage: req/ack handshake to data memory, byte-lane alignment, load extension.
// Latency: done one cycle after the final REQ cycle (fault path: cycle 1); stall holds the core meanwhile.
module load_store_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic             misaligned,
    output logic             bus_err,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           state, state_nxt;
    logic [2:0]       f3_q;
    logic             store_q;
    logic [1:0]       off_q;
    logic [CW-1:0]    cnt;
    logic             legal_f3, aligned, fault;
    logic [3:0]       be_new;
    logic [WIDTH-1:0] wdata_new;
    logic [WIDTH-1:0] lane, load_ext;

    always_comb begin
        aligned   = 1'b0;
        be_new    = 4'b0000;
        wdata_new = '0;
        case (funct3[1:0])
            2'b00: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr[0];
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            2'b10: begin
                aligned   = (addr[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
            default: ;
        endcase
        // Stores have no unsigned forms; loads have no unsigned word.
        if (is_store)
            legal_f3 = ~funct3[2] & (funct3[1:0] != 2'b11);
        else if (funct3[1:0] == 2'b10)
            legal_f3 = ~funct3[2];
        else
            legal_f3 = (funct3[1:0] != 2'b11);
        fault = ~legal_f3 | ~aligned;
    end

    assign lane = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_ext = lane;
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_valid) state_nxt = fault ? RESP : REQ;
            REQ:     if (dmem_ack || cnt == CNT_LAST) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q       <= '0;
            store_q    <= 1'b0;
            off_q      <= '0;
            cnt        <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    f3_q    <= funct3;
                    store_q <= is_store;
                    off_q   <= addr[1:0];
                    cnt     <= '0;
                    rdata   <= '0;
                    if (fault) begin
                        misaligned <= 1'b1;
                    end else begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {addr[WIDTH-1:2], 2'b00};
                        dmem_be    <= be_new;
                        dmem_wdata <= wdata_new;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rdata    <= store_q ? '0 : load_ext;
                    end else if (cnt == CNT_LAST) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        bus_err  <= 1'b1;
                        rdata    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    misaligned <= 1'b0;
                    bus_err    <= 1'b0;
                    rdata      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign done  = (state == RESP);
    // Reset gates stall directly so the core is released without waiting for a clock.
    assign stall = op_valid & (state != RESP) & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory reference model.
module tb_load_store_unit;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        clk, reset, op_valid, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, misaligned, bus_err;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    load_store_unit #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack)
    );

    typedef struct { logic [31:0] rdata; logic mis; logic berr; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int len; } req_t;

    resp_t       exp_q[$];
    req_t        req_q[$];
    logic [7:0]  ref_mem [0:31];
    logic [31:0] bus_mem [0:7];
    int          ack_delay;
    int          total, bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endfunction

    // Reference model: byte-addressed memory starting at 0x100, sizes 1/2/4 bytes.
    task automatic model_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int d, output int lat);
        int n, base;
        bit legal, fault;
        resp_t r;
        req_t q;
        logic [31:0] v;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n     = 1 << f3[1:0];
        fault = !legal || (int'(a) % n != 0);
        base  = int'(a) - 'h100;
        r     = '{32'd0, 1'b0, 1'b0};
        if (fault) begin
            r.mis = 1'b1;
            lat   = 1;
        end else begin
            q.we    = st;
            q.addr  = a & ~32'd3;
            q.be    = 4'(((1 << n) - 1) << (int'(a) % 4));
            q.wdata = '0;
            for (int i = 0; i < 4; i++) q.wdata[8*i +: 8] = 8'(wd >> (8 * (i % n)));
            if (d >= TIMEOUT) begin
                q.len  = TIMEOUT;
                r.berr = 1'b1;
                lat    = TIMEOUT + 1;
            end else begin
                q.len = d + 1;
                lat   = d + 2;
                if (st) begin
                    for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
                end else begin
                    v = 0;
                    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
                    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
                    r.rdata = v;
                end
            end
            req_q.push_back(q);
        end
        exp_q.push_back(r);
    endtask

    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int d, input bit drop);
        int lat;
        bit seen;
        @(negedge clk);
        is_store = st; funct3 = f3; addr = a; wdata = wd; ack_delay = d;
        model_txn(st, f3, a, wd, d, lat);
        op_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c <= TIMEOUT + 8; c++) begin
            #1;
            if (done) begin
                chk("done_latency", c, lat);
                chk("stall_at_done", stall, 1'b0);
                seen = 1'b1;
                break;
            end
            chk("stall", stall, op_valid);
            if (drop && c == 1) op_valid = 1'b0;
            @(negedge clk);
        end
        chk("done_seen", seen, 1'b1);
        op_valid = 1'b0;
    endtask

    // Memory responder: acks after ack_delay REQ cycles; stray acks while idle.
    initial begin
        int rcnt;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (dmem_req && !reset) begin
                if (rcnt == ack_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = bus_mem[dmem_addr[4:2]];
                    if (dmem_we)
                        for (int i = 0; i < 4; i++)
                            if (dmem_be[i]) bus_mem[dmem_addr[4:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
                end else begin
                    dmem_ack   = 1'b0;
                    dmem_rdata = $urandom;
                end
                rcnt++;
            end else begin
                rcnt       = 0;
                dmem_ack   = ($urandom_range(0, 1) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: completions against exp_q, memory requests against req_q.
    initial begin
        req_t  cur;
        resp_t e;
        int    len;
        bit    prev;
        prev = 1'b0;
        len  = 0;
        cur  = '{1'b0, 32'd0, 4'd0, 32'd0, 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                len  = 0;
                continue;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_without_txn", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("misaligned", misaligned, e.mis);
                    chk("bus_err", bus_err, e.berr);
                    if (misaligned) chk("we_on_fault", dmem_we, 1'b0);
                end
            end
            if (dmem_req) begin
                if (!prev) begin
                    if (req_q.size() == 0) chk("req_without_txn", req_q.size(), 1);
                    else cur = req_q.pop_front();
                    len = 0;
                end
                len++;
                chk("dmem_we", dmem_we, cur.we);
                chk("dmem_addr", dmem_addr, cur.addr);
                chk("dmem_be", dmem_be, cur.be);
                chk("dmem_wdata", dmem_wdata, cur.wdata);
            end else if (prev) begin
                chk("req_len", len, cur.len);
            end
            prev = dmem_req;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        total = 0; bad = 0;
        reset = 1'b1; op_valid = 1'b0; is_store = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; ack_delay = 0;
        for (int w = 0; w < 8; w++) begin
            bus_mem[w] = (w == 0) ? 32'hDEADBEEF : $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = bus_mem[w][8*b +: 8];
        end
        repeat (2) @(negedge clk);
        chk("rst_done", done, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_flags", {misaligned, bus_err}, 2'b00);
        chk("rst_req_we", {dmem_req, dmem_we}, 2'b00);
        chk("rst_dmem", dmem_addr | dmem_wdata | 32'(dmem_be), 32'd0);
        #1 reset = 1'b0;

        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);          // lw
        do_txn(1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0);          // lb
        do_txn(1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0);          // lbu
        do_txn(1'b0, 3'b001, 32'h102, 32'h0, 2, 1'b0);          // lh
        do_txn(1'b1, 3'b000, 32'h101, 32'h12345678, 0, 1'b0);   // sb
        do_txn(1'b1, 3'b001, 32'h102, 32'h12345678, 3, 1'b1);   // sh, op_valid dropped
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h102, 32'h0, 0, 1'b0);          // misaligned lw
        do_txn(1'b1, 3'b001, 32'h101, 32'h55AA55AA, 0, 1'b0);   // misaligned sh
        do_txn(1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b0);          // illegal load funct3
        do_txn(1'b1, 3'b100, 32'h104, 32'hFFFFFFFF, 0, 1'b0);   // illegal store funct3
        do_txn(1'b0, 3'b010, 32'h104, 32'h0, TIMEOUT - 1, 1'b0); // ack in last cycle
        do_txn(1'b0, 3'b010, 32'h104, 32'h0, NEVER, 1'b0);       // timeout

        // Reset in REQ cycle 3 aborts the access.
        @(negedge clk);
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h108; ack_delay = NEVER;
        model_txn(1'b0, 3'b010, 32'h108, 32'h0, NEVER, lat);
        op_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_abort_req", dmem_req, 1'b0);
        chk("rst_abort_stall", stall, 1'b0);
        chk("rst_abort_done", done, 1'b0);
        void'(exp_q.pop_back());
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            int d;
            d = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(0, 4));
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h100 + 32'($urandom_range(0, 31)), $urandom, d,
                   ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        chk("queues_drained", exp_q.size() + req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
